// File: rtl/rr_select_encoder.sv
// Registered select encoder with fixed or round-robin priority.
// One grant per accepted cycle; idx equals WIDTH when nothing is granted.
module rr_select_encoder #(
  parameter int WIDTH   = 16,
  parameter int IDX_W   = 5,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           select,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [IDX_W-1:0]           idx,
  output logic [$clog2(WIDTH)-1:0]   ptr
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] NONE = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  if (IDX_W != PW + 1) begin : g_bad_idx_w
    $error("rr_select_encoder: IDX_W must be clog2(WIDTH)+1");
  end

  logic                 accept;
  logic                 open;
  logic [PW-1:0]        ptr_inc;
  logic [PW-1:0]        ptr_nxt;
  logic [2*WIDTH-1:0]   dbl;
  logic [WIDTH-1:0]     rot;
  logic                 hit;
  logic [IDX_W-1:0]     grant;
  int                   pos;

  assign accept = out_valid & out_ready;
  assign open   = ~out_valid | out_ready;

  // Wrap at WIDTH, not at the next power of two.
  always_comb begin
    ptr_inc = '0;
    if (idx != LAST) begin
      ptr_inc = PW'(idx + IDX_W'(1));
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if ((RR_MODE != 0) && accept) begin
      ptr_nxt = ptr_inc;
    end
  end

  // Rotate so the priority line sits at bit 0, then take the lowest set bit.
  assign dbl = {select, select} >> ptr_nxt;
  assign rot = dbl[WIDTH-1:0];

  always_comb begin
    hit   = 1'b0;
    grant = NONE;
    pos   = 0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        pos = int'(ptr_nxt) + k;
        if (pos >= WIDTH) begin
          pos = pos - WIDTH;
        end
        grant = IDX_W'(pos);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      idx       <= NONE;
      ptr       <= '0;
    end else if (open) begin
      out_valid <= hit;
      idx       <= grant;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_select_encoder.sv
// Directed scoreboard bench for rr_select_encoder.
// Three instances: 16-line round-robin, 16-line fixed, 5-line round-robin.
module tb_rr_select_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, rst2;
  logic [15:0] sel0, sel1;
  logic [4:0]  sel2;
  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [4:0]  ix0, ix1;
  logic [3:0]  ix2;
  logic [3:0]  pt0, pt1;
  logic [2:0]  pt2;

  rr_select_encoder #(.WIDTH(16), .IDX_W(5), .RR_MODE(1)) u_rr16 (
    .clk(clk), .rst(rst0), .select(sel0), .out_ready(rdy0),
    .out_valid(ov0), .idx(ix0), .ptr(pt0)
  );

  rr_select_encoder #(.WIDTH(16), .IDX_W(5), .RR_MODE(0)) u_fx16 (
    .clk(clk), .rst(rst1), .select(sel1), .out_ready(rdy1),
    .out_valid(ov1), .idx(ix1), .ptr(pt1)
  );

  rr_select_encoder #(.WIDTH(5), .IDX_W(4), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst(rst2), .select(sel2), .out_ready(rdy2),
    .out_valid(ov2), .idx(ix2), .ptr(pt2)
  );

  typedef struct {
    int         d;
    logic [7:0] idx;
    logic       v;
    logic [7:0] ptr;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int d, input logic r, input logic [15:0] s,
                      input logic rd, input int ei, input logic ev,
                      input int ep, input string tag);
    exp_t e;
    logic [7:0] oi, op;
    logic ov;
    case (d)
      0: begin rst0 = r; sel0 = s; rdy0 = rd; end
      1: begin rst1 = r; sel1 = s; rdy1 = rd; end
      default: begin rst2 = r; sel2 = s[4:0]; rdy2 = rd; end
    endcase
    sb.push_back('{d, 8'(ei), ev, 8'(ep), tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    case (e.d)
      0: begin oi = 8'(ix0); ov = ov0; op = 8'(pt0); end
      1: begin oi = 8'(ix1); ov = ov1; op = 8'(pt1); end
      default: begin oi = 8'(ix2); ov = ov2; op = 8'(pt2); end
    endcase
    chk({e.tag, ".idx"}, oi, e.idx);
    chk({e.tag, ".valid"}, 8'(ov), 8'(e.v));
    chk({e.tag, ".ptr"}, op, e.ptr);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    sel0 = '0; sel1 = '0; sel2 = '0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst16.idx", 8'(ix0), 8'd16);
    chk("rst16.valid", 8'(ov0), 8'd0);
    chk("rst16.ptr", 8'(pt0), 8'd0);
    chk("rst5.idx", 8'(ix2), 8'd5);

    // Empty select
    for (int i = 0; i < 3; i++)
      step(0, 0, 16'h0000, 1, 16, 0, 0, "empty");

    // Two requesters alternate
    step(0, 0, 16'h8001, 1, 0, 1, 0, "alt0");
    step(0, 0, 16'h8001, 1, 15, 1, 1, "alt1");
    step(0, 0, 16'h8001, 1, 0, 1, 0, "alt2");
    step(0, 0, 16'h8001, 1, 15, 1, 1, "alt3");
    step(0, 0, 16'h0000, 1, 16, 0, 0, "alt_wrap");
    step(0, 0, 16'h0000, 1, 16, 0, 0, "empty_hold_ptr");

    // Stall holds result and ptr, even with select changing
    step(0, 0, 16'h0110, 0, 4, 1, 0, "stall0");
    step(0, 0, 16'h0110, 0, 4, 1, 0, "stall1");
    step(0, 0, 16'h0110, 0, 4, 1, 0, "stall2");
    step(0, 0, 16'h0000, 0, 4, 1, 0, "stall_sel0");
    step(0, 0, 16'h0110, 1, 8, 1, 5, "rel0");
    step(0, 0, 16'h0110, 1, 4, 1, 9, "rel1");
    step(0, 0, 16'h0110, 1, 8, 1, 5, "rel2");

    // Reset while stalled
    step(0, 0, 16'h0080, 1, 7, 1, 9, "pre7");
    step(0, 0, 16'h0080, 0, 7, 1, 9, "hold7");
    step(0, 1, 16'h0080, 1, 16, 0, 0, "rst_stall");
    step(0, 0, 16'h0080, 1, 7, 1, 0, "post_rst");

    // Fixed priority
    for (int i = 0; i < 4; i++)
      step(1, 0, 16'hFFF0, 1, 4, 1, 0, "fixed");
    step(1, 0, 16'h8000, 1, 15, 1, 0, "fixed_hi");
    step(1, 0, 16'h0003, 0, 15, 1, 0, "fixed_stall");
    step(1, 0, 16'h0003, 1, 0, 1, 0, "fixed_lo");
    step(1, 0, 16'h0000, 1, 16, 0, 0, "fixed_empty");

    // Non-power-of-two wrap
    step(2, 0, 16'h001F, 1, 0, 1, 0, "w5_0");
    step(2, 0, 16'h001F, 1, 1, 1, 1, "w5_1");
    step(2, 0, 16'h001F, 1, 2, 1, 2, "w5_2");
    step(2, 0, 16'h001F, 1, 3, 1, 3, "w5_3");
    step(2, 0, 16'h001F, 1, 4, 1, 4, "w5_4");
    step(2, 0, 16'h001F, 1, 0, 1, 0, "w5_wrap");
    step(2, 0, 16'h001F, 1, 1, 1, 1, "w5_6");
    step(2, 0, 16'h0000, 1, 5, 0, 2, "w5_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_select_encoder.md
RR_SELECT_ENCODER -- requirements
Module: rr_select_encoder

Interface
REQ-001 Parameter WIDTH, default 16: number of select lines; legal range 2..64.
REQ-002 Parameter IDX_W, default 5: idx width; SHALL equal clog2(WIDTH)+1 so that the value WIDTH is encodable.
REQ-003 Parameter RR_MODE, default 1: 0 = fixed lowest-index-first, 1 = round-robin rotating priority.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 select  input  WIDTH  request vector; bit i set = line i requesting.
REQ-007 out_ready  input  1  consumer accepts the held result this cycle.
REQ-008 out_valid  output  1  registered; idx holds a real grant.
REQ-009 idx  output  IDX_W  registered; granted line index, or WIDTH when there is no grant.
REQ-010 ptr  output  clog2(WIDTH)  registered; current highest-priority line, for debug.

Function
REQ-011 The output stage SHALL be "open" when out_valid=0 or (out_valid=1 and out_ready=1), and "stalled" otherwise.
REQ-012 When open, the block SHALL sample select on that edge and load the encode result into idx/out_valid; latency is 1 cycle from select to idx.
REQ-013 When stalled, idx, out_valid and ptr SHALL hold unchanged regardless of select.
REQ-014 Search order SHALL be ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1; the first set bit in this order SHALL be granted.
REQ-015 If select is all zero when sampled, the block SHALL load idx=WIDTH and out_valid=0.
REQ-016 If select is nonzero when sampled, the block SHALL load out_valid=1 and idx in 0..WIDTH-1.
REQ-017 RR_MODE=0: ptr SHALL be constant 0, so behaviour equals the lowest-set-bit priority encoder with a registered output.
REQ-018 RR_MODE=1: on an accept edge (out_valid=1 and out_ready=1), ptr SHALL load (idx+1) mod WIDTH, so idx=WIDTH-1 wraps ptr to 0.
REQ-019 The ptr update SHALL NOT occur without an accept; a dropped or empty result leaves ptr unchanged.
REQ-020 On an accept edge, the new sample SHALL use the updated ptr, giving back-to-back fair grants at one grant per cycle.
REQ-021 A requesting line SHALL be granted within WIDTH accepted grants while its select bit stays set (RR_MODE=1 starvation bound).
REQ-022 out_valid SHALL NOT rise combinationally from select; all outputs SHALL be flop outputs.
REQ-023 Sampling SHALL treat select as level-sensitive; it SHALL NOT be edge-detected or latched between samples.
REQ-024 WIDTH not a power of two: the ptr increment SHALL wrap at WIDTH, not at 2^clog2(WIDTH).

Reset
REQ-025 With rst=1 at an edge, the block SHALL set out_valid=0, idx=WIDTH and ptr=0, overriding any accept or stall.
REQ-026 A reset asserted while stalled SHALL discard the held grant; the first sample after rst falls SHALL be taken on the next edge.
REQ-027 While rst=1, out_ready SHALL be ignored.

Verification (WIDTH=16, IDX_W=5)
REQ-028 Reset, then select=0x0000 with out_ready=1 -> idx=16, out_valid=0, ptr=0 on every cycle.
REQ-029 RR_MODE=1, select=0x8001 held, out_ready=1 -> idx sequence 0,15,0,15 and ptr sequence 1,0,1,0 (ptr=15 occurs only if granted 14).
REQ-030 RR_MODE=1, select=0x0110, out_ready=0 for 3 cycles -> idx=4 held and ptr stays 0; when out_ready=1 the next idx is 8 and ptr goes 5 then 9.
REQ-031 RR_MODE=0, select=0xFFF0 with out_ready=1 for 4 cycles -> idx=4 every cycle and ptr=0.
REQ-032 Stalled with idx=7, assert rst for one cycle -> out_valid=0, idx=16, ptr=0; then select=0x0080 -> idx=7 one cycle after reset falls.
REQ-033 WIDTH=5, RR_MODE=1, select=0x1F held, out_ready=1 -> idx cycles 0,1,2,3,4,0 and ptr wraps from 4 to 0.
